booth_controller: RTL and testbench



---
 rtl/booth_pkg.sv | 35 +++
 rtl/booth_recode.sv | 35 +++
 rtl/booth_controller.sv | 162 ++++++++++++++++
 tb/tb_booth_controller.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/booth_pkg.sv
`default_nettype none
// ============================================================================
// Module  : booth_pkg
// Purpose : Shared encodings for the radix-4 Booth controller.
//           These are the datapath command codes (sig), the ALU op codes and
//           the controller state enumeration.
// Options : none (see booth_controller for BOOTH_PERF_EN)
// Revision: 1.0 - initial release
// ============================================================================
package booth_pkg;

    // Datapath command bus encodings (3 bits)
    localparam logic [2:0] SIG_ALU   = 3'b000;  // 0aa, aa = ALU op
    localparam logic [2:0] SIG_LOAD  = 3'b100;
    localparam logic [2:0] SIG_SHIFT = 3'b101;  // shift right by 2, decrement cnt
    localparam logic [2:0] SIG_NOP   = 3'b110;
    localparam logic [2:0] SIG_DONE  = 3'b111;

    // ALU op codes carried in sig[1:0] when sig[2] == 0
    localparam logic [1:0] ALU_ADD  = 2'b00;    // +M
    localparam logic [1:0] ALU_SUB  = 2'b01;    // -M
    localparam logic [1:0] ALU_ADD2 = 2'b10;    // +2M
    localparam logic [1:0] ALU_SUB2 = 2'b11;    // -2M

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_EVAL  = 3'd2,
        ST_ALU   = 3'd3,
        ST_SHIFT = 3'd4,
        ST_DONE  = 3'd5
    } state_e;

endpackage : booth_pkg
`default_nettype wire

// File: rtl/booth_recode.sv
`default_nettype none
// ============================================================================
// Module  : booth_recode
// Purpose : Combinational radix-4 Booth recoder.
//           Maps the triple {b1, b0, b-1} to a skip flag and an ALU op.
// Ports   : i_triple [2:0] - Booth triple {mplier[1:0], pl}
//           o_skip         - 1 when the digit is zero (000, 111, or unknown)
//           o_op     [1:0] - ALU op, valid when o_skip == 0
// Options : none
// Revision: 1.0 - initial release
// ============================================================================
module booth_recode
    import booth_pkg::*;
(
    input  logic [2:0] i_triple,
    output logic       o_skip,
    output logic [1:0] o_op
);

    // Any triple outside the listed codes (including X/Z) falls into the
    // default branch and is treated as a zero digit.
    always_comb begin
        o_skip = 1'b1;
        o_op   = ALU_ADD;
        case (i_triple)
            3'b001, 3'b010: begin o_skip = 1'b0; o_op = ALU_ADD;  end
            3'b011:         begin o_skip = 1'b0; o_op = ALU_ADD2; end
            3'b100:         begin o_skip = 1'b0; o_op = ALU_SUB2; end
            3'b101, 3'b110: begin o_skip = 1'b0; o_op = ALU_SUB;  end
            default:        begin o_skip = 1'b1; o_op = ALU_ADD;  end
        endcase
    end

endmodule : booth_recode
`default_nettype wire

// File: rtl/booth_controller.sv
`default_nettype none
// ============================================================================
// Module  : booth_controller
// Purpose : Control FSM for a radix-4 Booth multiplier datapath.
//           Issues load, recoded ALU ops and shift/decrement commands until
//           the datapath counter reaches zero, then pulses done.
// Ports   : clk, rst        - clock, synchronous active-high reset
//           start           - request a multiply (sampled in IDLE only)
//           status [2:0]    - Booth triple {mplier[1:0], pl}
//           cnt [CNT_W-1:0] - datapath iteration counter
//           sig [2:0]       - registered datapath command
//           busy            - high from LOAD through DONE
//           done            - one-cycle completion pulse
//           cycles [7:0]    - (BOOTH_PERF_EN only) LOAD..DONE cycle count
//                             of the last completed multiply
// Options : BOOTH_PERF_EN - adds the cycles output and its counter
// Revision: 1.0 - initial release
// ============================================================================
module booth_controller
    import booth_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       status,
    input  logic [CNT_W-1:0] cnt,
    output logic [2:0]       sig,
    output logic             busy,
    output logic             done
`ifdef BOOTH_PERF_EN
    ,
    output logic [7:0]       cycles
`endif
);

    localparam logic [2:0] S_IDLE  = ST_IDLE;
    localparam logic [2:0] S_LOAD  = ST_LOAD;
    localparam logic [2:0] S_EVAL  = ST_EVAL;
    localparam logic [2:0] S_ALU   = ST_ALU;
    localparam logic [2:0] S_SHIFT = ST_SHIFT;
    localparam logic [2:0] S_DONE  = ST_DONE;

    logic [2:0] r_state;
    logic [2:0] w_state_next;
    logic [2:0] r_sig;
    logic [2:0] w_sig_next;
    logic       r_busy;
    logic       r_done;
    logic       w_skip;
    logic [1:0] w_op;

    booth_recode u_recode (
        .i_triple (status),
        .o_skip   (w_skip),
        .o_op     (w_op)
    );

    // Next state and the command that goes with it. Outputs are registered
    // from the next state so sig always reflects the state being entered.
    // The recoded op is captured straight into the sig register on the
    // EVAL->ALU edge, so no separate op latch is needed.
    always_comb begin
        w_state_next = r_state;
        w_sig_next   = SIG_NOP;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_next = S_LOAD;
                    w_sig_next   = SIG_LOAD;
                end
            end
            S_LOAD: begin
                w_state_next = S_EVAL;
                w_sig_next   = SIG_NOP;
            end
            S_EVAL: begin
                if (cnt == '0) begin
                    w_state_next = S_DONE;
                    w_sig_next   = SIG_DONE;
                end else if (w_skip) begin
                    w_state_next = S_SHIFT;
                    w_sig_next   = SIG_SHIFT;
                end else begin
                    w_state_next = S_ALU;
                    w_sig_next   = {1'b0, w_op};
                end
            end
            S_ALU: begin
                w_state_next = S_SHIFT;
                w_sig_next   = SIG_SHIFT;
            end
            S_SHIFT: begin
                w_state_next = S_EVAL;
                w_sig_next   = SIG_NOP;
            end
            S_DONE: begin
                w_state_next = S_IDLE;
                w_sig_next   = SIG_NOP;
            end
            default: begin
                w_state_next = S_IDLE;
                w_sig_next   = SIG_NOP;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_sig   <= SIG_NOP;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_sig   <= w_sig_next;
            r_busy  <= (w_state_next != S_IDLE);
            r_done  <= (w_state_next == S_DONE);
        end
    end

    assign sig  = r_sig;
    assign busy = r_busy;
    assign done = r_done;

`ifdef BOOTH_PERF_EN
    logic [7:0] r_perf;
    logic [7:0] r_cycles;
    logic [7:0] w_perf_next;

    // The count includes the current cycle: LOAD restarts at 1 and every
    // later busy cycle adds one, so the value seen in DONE covers LOAD..DONE.
    always_comb begin
        if (r_state == S_LOAD) begin
            w_perf_next = 8'd1;
        end else if (r_perf != 8'hFF) begin
            w_perf_next = r_perf + 8'd1;
        end else begin
            w_perf_next = r_perf;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf   <= 8'd0;
            r_cycles <= 8'd0;
        end else begin
            if (r_busy) begin
                r_perf <= w_perf_next;
            end
            if (r_state == S_DONE) begin
                r_cycles <= w_perf_next;
            end
        end
    end

    assign cycles = r_cycles;
`endif

endmodule : booth_controller
`default_nettype wire

// File: tb/tb_booth_controller.sv
`default_nettype none
// ============================================================================
// Module  : tb_booth_controller
// Purpose : Self-checking bench for booth_controller. A small datapath model
//           answers the LOAD/SHIFT commands with cnt and the Booth triple; the
//           expected command trace is derived from the Booth digit value of
//           each triple.
// Options : BOOTH_PERF_EN - also checks the cycles output
// Revision: 1.0 - initial release
// ============================================================================
module tb_booth_controller;

    logic       clk;
    logic       rst;
    logic       start;
    logic [2:0] status;
    logic [7:0] cnt;
    logic [2:0] sig;
    logic       busy;
    logic       done;
`ifdef BOOTH_PERF_EN
    logic [7:0] cycles;
`endif

    int total = 0;
    int bad   = 0;

    booth_controller #(.CNT_W(8)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .status (status),
        .cnt    (cnt),
        .sig    (sig),
        .busy   (busy),
        .done   (done)
`ifdef BOOTH_PERF_EN
        ,
        .cycles (cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Datapath model: LOAD sets the counter, SHIFT decrements it and steps
    // to the next multiplier triple.
    logic [2:0] stat_tbl [0:15];
    logic [7:0] load_val;
    logic [7:0] dp_cnt;
    int         it;

    initial begin
        dp_cnt = 8'd0;
        it     = 0;
    end

    always @(posedge clk) begin
        if (sig == 3'b100) begin
            dp_cnt <= load_val;
            it     <= 0;
        end else if (sig == 3'b101) begin
            dp_cnt <= dp_cnt - 8'd1;
            it     <= it + 1;
        end
    end

    assign cnt    = dp_cnt;
    assign status = (it < 16) ? stat_tbl[it] : 3'b000;

    // Radix-4 Booth digit: -2*b1 + b0 + b-1 (unknown triple -> 0)
    function automatic int booth_digit(input logic [2:0] t);
        if ($isunknown(t)) return 0;
        return -2 * int'(t[2]) + int'(t[1]) + int'(t[0]);
    endfunction

    function automatic logic [2:0] digit_cmd(input int d);
        case (d)
            1:       return 3'b000;
            -1:      return 3'b001;
            2:       return 3'b010;
            default: return 3'b011;   // -2
        endcase
    endfunction

    // Runs one multiply of n iterations using stat_tbl and checks every
    // cycle from LOAD through DONE, then the IDLE cycle after.
    // hold : leave start high at the end (back-to-back)
    // poke : pulse start while busy, must be ignored
    task automatic run_op(input int n, input bit hold, input bit poke, input string tag);
        logic [2:0] exp_q[$];
        int d;
        exp_q = {};
        exp_q.push_back(3'b100);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(3'b110);
            d = booth_digit(stat_tbl[i]);
            if (d != 0) exp_q.push_back(digit_cmd(d));
            exp_q.push_back(3'b101);
        end
        exp_q.push_back(3'b110);
        exp_q.push_back(3'b111);

        load_val = n[7:0];
        start    = 1'b1;
        for (int k = 0; k < exp_q.size(); k++) begin
            @(negedge clk);
            total++;
            if (sig !== exp_q[k]) begin
                bad++;
                $display("FAIL %s sig cycle %0d: got %b expected %b", tag, k + 1, sig, exp_q[k]);
            end
            total++;
            if (busy !== 1'b1) begin
                bad++;
                $display("FAIL %s busy cycle %0d: got %b expected 1", tag, k + 1, busy);
            end
            total++;
            if (done !== (k == exp_q.size() - 1)) begin
                bad++;
                $display("FAIL %s done cycle %0d: got %b expected %b", tag, k + 1, done,
                         (k == exp_q.size() - 1));
            end
            if (k == 0 && !hold) start = 1'b0;
            if (poke && k == 1) start = 1'b1;
            if (poke && k == 2) start = 1'b0;
        end
        @(negedge clk);
        total++;
        if (sig !== 3'b110 || busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL %s idle after done: sig=%b busy=%b done=%b expected 110/0/0",
                     tag, sig, busy, done);
        end
`ifdef BOOTH_PERF_EN
        total++;
        if (cycles !== 8'(exp_q.size())) begin
            bad++;
            $display("FAIL %s cycles: got %0d expected %0d", tag, cycles, exp_q.size());
        end
`endif
    endtask

    task automatic fill_tbl(input logic [2:0] v);
        for (int i = 0; i < 16; i++) stat_tbl[i] = v;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        start = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++;
        if (sig !== 3'b110 || busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL reset state: sig=%b busy=%b done=%b expected 110/0/0", sig, busy, done);
        end
`ifdef BOOTH_PERF_EN
        total++;
        if (cycles !== 8'd0) begin
            bad++;
            $display("FAIL reset cycles: got %0d expected 0", cycles);
        end
`endif
        start = 1'b0;
        rst   = 1'b0;
        @(negedge clk);
        total++;
        if (sig !== 3'b110 || busy !== 1'b0) begin
            bad++;
            $display("FAIL idle after reset: sig=%b busy=%b expected 110/0", sig, busy);
        end
    endtask

    task automatic test_zero_mplier;
        fill_tbl(3'b000);
        run_op(8, 1'b0, 1'b0, "zero_mplier");
    endtask

    task automatic test_all_011;
        fill_tbl(3'b011);
        run_op(8, 1'b0, 1'b0, "all_011");
    endtask

    task automatic test_sequence;
        logic [2:0] seq [0:7];
        seq = '{3'b001, 3'b100, 3'b101, 3'b110, 3'b111, 3'b010, 3'b000, 3'b011};
        fill_tbl(3'b000);
        for (int i = 0; i < 8; i++) stat_tbl[i] = seq[i];
        run_op(8, 1'b0, 1'b0, "sequence");
    endtask

    task automatic test_start_ignored;
        fill_tbl(3'b011);
        run_op(0, 1'b0, 1'b1, "start_ignored");
        // The poked start must not have been queued
        @(negedge clk);
        total++;
        if (sig !== 3'b110 || busy !== 1'b0) begin
            bad++;
            $display("FAIL start_ignored restart: sig=%b busy=%b expected 110/0", sig, busy);
        end
    endtask

    task automatic test_back_to_back;
        fill_tbl(3'b000);
        run_op(8, 1'b1, 1'b0, "b2b_first");
        fill_tbl(3'b011);
        run_op(8, 1'b0, 1'b0, "b2b_second");
    endtask

    task automatic test_x_status;
        fill_tbl(3'bxxx);
        stat_tbl[1] = 3'b100;
        run_op(4, 1'b0, 1'b0, "x_status");
    endtask

    task automatic test_reset_mid;
        bit seen;
        fill_tbl(3'b011);
        load_val = 8'd8;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            if (sig[2] === 1'b0) seen = 1'b1;
            else @(negedge clk);
        end
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL reset_mid no ALU cycle: sig=%b expected 0xx within 10 cycles", sig);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        total++;
        if (sig !== 3'b110 || busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid abort: sig=%b busy=%b done=%b expected 110/0/0", sig, busy, done);
        end
        repeat (2) @(negedge clk);
        total++;
        if (sig !== 3'b110 || busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid stays idle: sig=%b busy=%b expected 110/0", sig, busy);
        end
        fill_tbl(3'b000);
        run_op(3, 1'b0, 1'b0, "reset_mid_restart");
    endtask

    task automatic test_random;
        int n;
        for (int r = 0; r < 25; r++) begin
            for (int i = 0; i < 16; i++) stat_tbl[i] = 3'($urandom_range(0, 7));
            n = $urandom_range(0, 8);
            run_op(n, 1'b0, 1'b0, "random");
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        load_val = 8'd0;
        fill_tbl(3'b000);
        test_reset;
        test_zero_mplier;
        test_all_011;
        test_sequence;
        test_start_ignored;
        test_back_to_back;
        test_x_status;
        test_reset_mid;
        test_random;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_booth_controller
`default_nettype wire
